ahb_decode_ctrl: RTL and testbench
==================================

Name: ahb_decode_ctrl

Overview:
- Address decoder and data-phase select controller for the two-slave AHB-Lite response path.
- Decodes HADDR in the address phase and drives combinational HSEL0/HSEL1 to the slaves.
- Registers the selection into the data phase to steer the response mux (HRDATA/HRESP/HREADY).
- Contains an internal default slave: unmapped active transfers get a two-cycle AHB ERROR response; the block overrides the mux's HREADY/HRESP to the master while the default slave owns the data phase.

Parameters:
- ADDR_WIDTH, 32, HADDR width.
- REGION_BITS, 28, each slave region is 2^REGION_BITS bytes; HADDR[ADDR_WIDTH-1:REGION_BITS] is compared.
- SLV0_BASE, 32'h0000_0000, slave 0 base address (aligned to region size).
- SLV1_BASE, 32'h1000_0000, slave 1 base address (aligned to region size).
- CNT_WIDTH, 8, decode-error counter width.

Ports:
- HCLK  in  1  system clock, rising edge.
- HRESET  in  1  asynchronous reset, active-high.
- HADDR  in  ADDR_WIDTH  master address.
- HTRANS  in  2  master transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- HSEL0  out  1  address-phase select, slave 0 (combinational).
- HSEL1  out  1  address-phase select, slave 1 (combinational).
- DP_SEL0  out  1  registered data-phase select to mux HSEL0 input.
- DP_SEL1  out  1  registered data-phase select to mux HSEL1 input.
- MUX_HREADY  in  1  HREADY from response mux.
- MUX_HRESP  in  1  HRESP from response mux.
- HREADY  out  1  final HREADY to master and all slaves.
- HRESP  out  1  final HRESP to master (0 OKAY, 1 ERROR).
- ERR_CNT  out  CNT_WIDTH  saturating count of decode errors.
- ERR_CLR  in  1  synchronous clear of ERR_CNT.

Behaviour:
- Decode (combinational, not gated by HTRANS): HSEL0=1 if HADDR upper bits match SLV0_BASE; else HSEL1=1 if they match SLV1_BASE. Overlap: slave 0 wins. No match: both 0 (unmapped).
- Data-phase register dp_sel ∈ {S0, S1, DEF}, loaded on rising HCLK only when HREADY=1. Loads S0/S1/DEF from decode. Holds while HREADY=0.
- DP_SEL0 = (dp_sel==S0); DP_SEL1 = (dp_sel==S1); both 0 for DEF.
- dp_sel=S0/S1: HREADY=MUX_HREADY and HRESP=MUX_HRESP (pass-through).
- Default-slave FSM states: OK, ERR1, ERR2.
  - OK → ERR1 on HCLK when HREADY=1, decode unmapped, HTRANS[1]=1 (NONSEQ/SEQ).
  - ERR1 → ERR2 unconditionally.
  - ERR2 → ERR1 if a new unmapped NONSEQ/SEQ is accepted that cycle; otherwise → OK.
  - Unmapped IDLE/BUSY leaves the FSM in OK.
- Outputs when dp_sel=DEF:
  - OK: HREADY=1, HRESP=0 (zero-wait OKAY).
  - ERR1: HREADY=0, HRESP=1.
  - ERR2: HREADY=1, HRESP=1.
- ERR1 forces HREADY=0, so no address is accepted during ERR1. The master may replace HTRANS with IDLE during ERR1 (AHB-Lite cancel); the block does not depend on it.
- ERR_CNT increments by 1 on each OK/ERR2 → ERR1 transition. It saturates at all-ones with no wrap. ERR_CLR has priority over a simultaneous increment (result 0).
- Reset (async, immediate): dp_sel=DEF, FSM=OK, ERR_CNT=0. Resulting outputs: DP_SEL0=0, DP_SEL1=0, HREADY=1, HRESP=0. HSEL0/HSEL1 follow HADDR even during reset.
- Reset asserted mid-error (ERR1/ERR2) aborts the response; HREADY=1 and HRESP=0 immediately.
- Latency: decode is 0 cycles; data-phase select follows 1 accepted cycle later; an error response is exactly 2 cycles.

Test Plan:
- Reset release, HTRANS=IDLE -> HREADY=1, HRESP=0, DP_SEL0=DP_SEL1=0, ERR_CNT=0.
- NONSEQ HADDR=32'h1000_0040, slave stalls 2 cycles (MUX_HREADY=0,0,1) -> HSEL1=1 in address phase; DP_SEL1=1 next cycle and held 3 cycles; HREADY mirrors MUX_HREADY.
- NONSEQ HADDR=32'h8000_0000 -> next cycle HREADY=0/HRESP=1, then HREADY=1/HRESP=1; ERR_CNT=1.
- Back-to-back unmapped SEQ presented during ERR2 -> ERR1,ERR2,ERR1,ERR2 sequence; ERR_CNT=2.
- IDLE to 32'hF000_0000 -> zero-wait OKAY, ERR_CNT unchanged.
- Force ERR_CNT to 255 via 255 errors, then another error -> stays 255. Assert ERR_CLR together with an error -> 0. Assert HRESET during ERR1 -> HREADY=1, HRESP=0 in the same cycle.

Source files
------------

// File: rtl/ahb_decode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ahb_decode_ctrl
// Desc     : Two-slave AHB-Lite address decoder with data-phase select and an
//            internal default slave that returns a two-cycle ERROR response.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_decode_ctrl #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    REGION_BITS = 28,
  parameter logic [ADDR_WIDTH-1:0] SLV0_BASE   = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] SLV1_BASE   = 32'h1000_0000,
  parameter int                    CNT_WIDTH   = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  output logic                  HSEL0,
  output logic                  HSEL1,
  output logic                  DP_SEL0,
  output logic                  DP_SEL1,
  input  logic                  MUX_HREADY,
  input  logic                  MUX_HRESP,
  output logic                  HREADY,
  output logic                  HRESP,
  output logic [CNT_WIDTH-1:0]  ERR_CNT,
  input  logic                  ERR_CLR
);

  localparam int TAG_W = ADDR_WIDTH - REGION_BITS;

  localparam logic [1:0] DP_DEF = 2'd0;
  localparam logic [1:0] DP_S0  = 2'd1;
  localparam logic [1:0] DP_S1  = 2'd2;

  localparam logic [1:0] ST_OK   = 2'd0;
  localparam logic [1:0] ST_ERR1 = 2'd1;
  localparam logic [1:0] ST_ERR2 = 2'd2;

  logic [TAG_W-1:0]     addr_tag;
  logic                 hsel0;
  logic                 hsel1;
  logic                 unmapped;
  logic                 err_start;
  logic                 hready;
  logic                 hresp;
  logic [1:0]           dp_sel_d, dp_sel_q;
  logic [1:0]           state_d, state_q;
  logic [CNT_WIDTH-1:0] err_cnt_d, err_cnt_q;
  logic                 unused_bits;

  // Offset bits within a region and the BUSY/SEQ distinction play no role here.
  assign addr_tag    = HADDR[ADDR_WIDTH-1:REGION_BITS];
  assign unused_bits = ^{HADDR[REGION_BITS-1:0], HTRANS[0]};

  always_comb begin
    hsel0    = (addr_tag == SLV0_BASE[ADDR_WIDTH-1:REGION_BITS]);
    hsel1    = !hsel0 && (addr_tag == SLV1_BASE[ADDR_WIDTH-1:REGION_BITS]);
    unmapped = !hsel0 && !hsel1;
  end

  assign err_start = hready && unmapped && HTRANS[1];

  always_comb begin
    dp_sel_d = dp_sel_q;
    if (hready) begin
      if (hsel0)      dp_sel_d = DP_S0;
      else if (hsel1) dp_sel_d = DP_S1;
      else            dp_sel_d = DP_DEF;
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (ERR_CLR)
      err_cnt_d = '0;
    else if (err_start && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_sel_q  <= DP_DEF;
      err_cnt_q <= '0;
    end else begin
      dp_sel_q  <= dp_sel_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Default-slave FSM: state register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state_q <= ST_OK;
    else        state_q <= state_d;
  end

  // Default-slave FSM: next state
  always_comb begin
    state_d = ST_OK;
    case (state_q)
      ST_OK:   state_d = err_start ? ST_ERR1 : ST_OK;
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = err_start ? ST_ERR1 : ST_OK;
      default: state_d = ST_OK;
    endcase
  end

  // Default-slave FSM: outputs; it only owns the response while dp_sel is DEF
  always_comb begin
    hready = MUX_HREADY;
    hresp  = MUX_HRESP;
    if (dp_sel_q == DP_DEF) begin
      case (state_q)
        ST_ERR1: begin hready = 1'b0; hresp = 1'b1; end
        ST_ERR2: begin hready = 1'b1; hresp = 1'b1; end
        default: begin hready = 1'b1; hresp = 1'b0; end
      endcase
    end
  end

  assign HSEL0   = hsel0;
  assign HSEL1   = hsel1;
  assign DP_SEL0 = (dp_sel_q == DP_S0);
  assign DP_SEL1 = (dp_sel_q == DP_S1);
  assign HREADY  = hready;
  assign HRESP   = hresp;
  assign ERR_CNT = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_decode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_decode_ctrl
// Desc     : Randomized and directed bench for ahb_decode_ctrl against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_decode_ctrl;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HSEL0, HSEL1, DP_SEL0, DP_SEL1;
  logic        MUX_HREADY, MUX_HRESP;
  logic        HREADY, HRESP;
  logic [7:0]  ERR_CNT;
  logic        ERR_CLR;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  ahb_decode_ctrl dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSEL0(HSEL0), .HSEL1(HSEL1), .DP_SEL0(DP_SEL0), .DP_SEL1(DP_SEL1),
    .MUX_HREADY(MUX_HREADY), .MUX_HRESP(MUX_HRESP),
    .HREADY(HREADY), .HRESP(HRESP), .ERR_CNT(ERR_CNT), .ERR_CLR(ERR_CLR)
  );

  always #5 HCLK = ~HCLK;

  // Reference model: who owns the data phase (0=slave0, 1=slave1, 2=default),
  // how many ERROR cycles are still owed, and the error tally.
  int m_owner    = 2;
  int m_err_left = 0;
  int m_cnt      = 0;

  function automatic int target_of(logic [31:0] a);
    int region;
    region = int'(a / 32'h1000_0000);
    if (region == 0) return 0;
    if (region == 1) return 1;
    return 2;
  endfunction

  function automatic bit exp_ready();
    if (m_owner < 2) return MUX_HREADY;
    return (m_err_left != 2);
  endfunction

  function automatic bit exp_resp();
    if (m_owner < 2) return MUX_HRESP;
    return (m_err_left > 0);
  endfunction

  always @(posedge HCLK or posedge HRESET) begin : model
    bit acc, new_err;
    int tgt;
    if (HRESET) begin
      m_owner    <= 2;
      m_err_left <= 0;
      m_cnt      <= 0;
    end else begin
      acc     = exp_ready();
      tgt     = target_of(HADDR);
      new_err = acc && (tgt == 2) && (HTRANS >= 2'd2);
      if (acc) m_owner <= tgt;
      m_err_left <= new_err ? 2 : ((m_err_left > 0) ? m_err_left - 1 : 0);
      if (ERR_CLR)      m_cnt <= 0;
      else if (new_err) m_cnt <= (m_cnt >= 255) ? 255 : m_cnt + 1;
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge HCLK) begin
    if (chk_en) begin
      check("hsel0",   HSEL0,   target_of(HADDR) == 0);
      check("hsel1",   HSEL1,   target_of(HADDR) == 1);
      check("dp_sel0", DP_SEL0, m_owner == 0);
      check("dp_sel1", DP_SEL1, m_owner == 1);
      check("hready",  HREADY,  exp_ready());
      check("hresp",   HRESP,   exp_resp());
      check("err_cnt", ERR_CNT, m_cnt);
    end
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    int waited;
    HRESET = 1'b1; HADDR = 32'h1000_0040; HTRANS = 2'b00;
    MUX_HREADY = 1'b1; MUX_HRESP = 1'b0; ERR_CLR = 1'b0;
    repeat (3) step();
    check("rst_hsel1_follows", HSEL1, 1);
    check("rst_hready", HREADY, 1);
    check("rst_hresp", HRESP, 0);
    HRESET = 1'b0;
    step();
    chk_en = 1'b1;
    check("idle_dp_sel0", DP_SEL0, 0);
    check("idle_err_cnt", ERR_CNT, 0);

    // Slave 1 access with two wait states
    HADDR = 32'h1000_0040; HTRANS = 2'b10; #1;
    check("s1_hsel1", HSEL1, 1);
    check("s1_hsel0", HSEL0, 0);
    step();
    HTRANS = 2'b00; HADDR = 32'h0; MUX_HREADY = 1'b0; #1;
    check("s1_dp1_a", DP_SEL1, 1);
    check("s1_wait_a", HREADY, 0);
    step(); #1;
    check("s1_dp1_b", DP_SEL1, 1);
    check("s1_wait_b", HREADY, 0);
    step();
    MUX_HREADY = 1'b1; #1;
    check("s1_dp1_c", DP_SEL1, 1);
    check("s1_done", HREADY, 1);
    step();
    check("s0_dp0", DP_SEL0, 1);

    // Single unmapped NONSEQ
    HADDR = 32'h8000_0000; HTRANS = 2'b10;
    step();
    HTRANS = 2'b00; #1;
    check("err1_hready", HREADY, 0);
    check("err1_hresp", HRESP, 1);
    check("err1_cnt", ERR_CNT, 1);
    step();
    check("err2_hready", HREADY, 1);
    check("err2_hresp", HRESP, 1);
    step();
    check("ok_hresp", HRESP, 0);

    // Back-to-back errors
    ERR_CLR = 1'b1; step(); ERR_CLR = 1'b0;
    HTRANS = 2'b10; step();
    HTRANS = 2'b11; #1;
    check("b2b_e1_ready", HREADY, 0);
    step();
    check("b2b_e2_resp", HRESP, 1);
    step();
    HTRANS = 2'b00; #1;
    check("b2b_e1b_ready", HREADY, 0);
    step();
    check("b2b_e2b_ready", HREADY, 1);
    check("b2b_cnt", ERR_CNT, 2);

    // Unmapped IDLE is a zero-wait OKAY
    HADDR = 32'hF000_0000; step(); step();
    check("idle_unmapped_ready", HREADY, 1);
    check("idle_unmapped_resp", HRESP, 0);
    check("idle_unmapped_cnt", ERR_CNT, 2);

    // Counter saturation
    HTRANS = 2'b10;
    repeat (600) step();
    check("sat_cnt", ERR_CNT, 255);
    waited = 0;
    while (!HREADY && waited < 4) begin step(); waited++; end
    check("sat_align_timeout", int'(HREADY), 1);
    ERR_CLR = 1'b1; step(); ERR_CLR = 1'b0; #1;
    check("clr_wins", ERR_CNT, 0);
    check("pre_rst_err1", HREADY, 0);
    HRESET = 1'b1; #1;
    check("rst_abort_ready", HREADY, 1);
    check("rst_abort_resp", HRESP, 0);
    HTRANS = 2'b00;
    step();
    HRESET = 1'b0;
    step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      HADDR = $urandom;
      case ($urandom_range(0, 3))
        0:       HADDR[31:28] = 4'h0;
        1:       HADDR[31:28] = 4'h1;
        default: ;
      endcase
      HTRANS     = 2'($urandom_range(0, 3));
      MUX_HREADY = ($urandom_range(0, 3) != 0);
      MUX_HRESP  = ($urandom_range(0, 7) == 0);
      ERR_CLR    = ($urandom_range(0, 31) == 0);
      step();
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
